// File: rtl/reg_file_pkg.sv
// reg_file_pkg
// Shared types and helpers for the register file slice.
//   rf_state_t : clear-engine state encoding
//   rf_addr_w  : address width for a given depth (clog2, minimum 1)
package reg_file_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  function automatic int rf_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reg_word.sv
// reg_word
// One WIDTH-bit storage word of the register file.
//   clk   : rising-edge clock
//   rst_n : async active-low reset, clears q
//   ld    : load d into q at the edge
//   clr   : synchronous clear, wins over ld
//   d     : load data
//   q     : stored word
module reg_word #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file.sv
// reg_file
// WIDTH x DEPTH register file: one synchronous write port, two registered
// read ports, optional write-to-read bypass and a one-entry-per-cycle
// clear engine.
//   clk, rst_n       : clock, async active-low reset
//   we/waddr/wdata   : write port (ignored while busy)
//   raddr_a/rdata_a  : read port A, 1-cycle registered
//   raddr_b/rdata_b  : read port B, 1-cycle registered
//   clr_req          : start a clear sweep (sampled in IDLE only)
//   busy             : clear sweep in progress
//   wr_drop          : pulse, a write was discarded during the sweep
//
// state    | meaning
// RF_IDLE  | normal read/write, waiting for clr_req
// RF_CLEAR | zeroing mem[ptr] each edge, writes dropped, reads forced to 0
module reg_file
  import reg_file_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int DEPTH  = 8,
  parameter  int BYPASS = 1,
  localparam int ADDR_W = rf_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_drop
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  rf_state_t         state;
  logic [ADDR_W-1:0] ptr;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic wr_ok;
  logic byp_a;
  logic byp_b;

  assign wr_ok = we && (state == RF_IDLE);
  assign byp_a = (BYPASS != 0) && wr_ok && (waddr == raddr_a);
  assign byp_b = (BYPASS != 0) && wr_ok && (waddr == raddr_b);

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic ld;
    logic clr;
    assign ld  = wr_ok && (waddr == ADDR_W'(g));
    assign clr = (state == RF_CLEAR) && (ptr == ADDR_W'(g));

    reg_word #(.WIDTH(WIDTH)) u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (ld),
      .clr   (clr),
      .d     (wdata),
      .q     (mem_q[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RF_IDLE;
      ptr     <= '0;
      busy    <= 1'b0;
      wr_drop <= 1'b0;
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      case (state)
        RF_IDLE: begin
          wr_drop <= 1'b0;
          rdata_a <= byp_a ? wdata : mem_q[raddr_a];
          rdata_b <= byp_b ? wdata : mem_q[raddr_b];
          if (clr_req) begin
            state <= RF_CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        RF_CLEAR: begin
          wr_drop <= we;
          rdata_a <= '0;
          rdata_b <= '0;
          ptr     <= ptr + ADDR_W'(1);
          if (ptr == LAST) begin
            state <= RF_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= RF_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk;
  logic             rst_n;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;
  logic             clr_req;

  logic [WIDTH-1:0] rdata_a1, rdata_b1, rdata_a0, rdata_b0;
  logic             busy1, busy0, drop1, drop0;

  int errors = 0;
  int checks = 0;

  // reference model: contents plus index of the next entry to clear (-1 = no sweep)
  logic [WIDTH-1:0] mem_m [DEPTH];
  int               sweep;

  reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a1), .raddr_b(raddr_b), .rdata_b(rdata_b1),
    .clr_req(clr_req), .busy(busy1), .wr_drop(drop1)
  );

  reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a0), .raddr_b(raddr_b), .rdata_b(rdata_b0),
    .clr_req(clr_req), .busy(busy0), .wr_drop(drop0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    sweep = -1;
  endtask

  // Drive one cycle, advance the model across the edge, compare #1 after it.
  task automatic step(input logic i_we, input int i_wa, input logic [WIDTH-1:0] i_wd,
                      input int i_ra, input int i_rb, input logic i_clr);
    logic [WIDTH-1:0] ea1, eb1, ea0, eb0;
    logic ed;
    we = i_we; waddr = AW'(i_wa); wdata = i_wd;
    raddr_a = AW'(i_ra); raddr_b = AW'(i_rb); clr_req = i_clr;
    if (sweep >= 0) begin
      ea1 = '0; eb1 = '0; ea0 = '0; eb0 = '0;
      ed = i_we;
      mem_m[sweep] = '0;
      sweep = (sweep == DEPTH - 1) ? -1 : sweep + 1;
    end else begin
      ed  = 1'b0;
      ea0 = mem_m[i_ra];
      eb0 = mem_m[i_rb];
      ea1 = (i_we && i_wa == i_ra) ? i_wd : ea0;
      eb1 = (i_we && i_wa == i_rb) ? i_wd : eb0;
      if (i_we) mem_m[i_wa] = i_wd;
      if (i_clr) sweep = 0;
    end
    @(posedge clk);
    #1;
    check("rdata_a bypass", 32'(rdata_a1), 32'(ea1));
    check("rdata_b bypass", 32'(rdata_b1), 32'(eb1));
    check("rdata_a nobypass", 32'(rdata_a0), 32'(ea0));
    check("rdata_b nobypass", 32'(rdata_b0), 32'(eb0));
    check("busy", 32'(busy1), 32'(sweep >= 0));
    check("busy nobypass", 32'(busy0), 32'(sweep >= 0));
    check("wr_drop", 32'(drop1), 32'(ed));
  endtask

  typedef struct {
    logic             we;
    int               wa;
    logic [WIDTH-1:0] wd;
    int               ra;
    int               rb;
    logic [WIDTH-1:0] exp_a1;
    logic [WIDTH-1:0] exp_a0;
    logic [WIDTH-1:0] exp_b;
  } vec_t;

  vec_t vecs [5];

  int cnt_busy, cnt_drop, cnt_low, guard;

  initial begin
    // hand-derived expectations starting from an all-zero array
    vecs[0] = '{1'b1, 3, 16'hBEEF, 0, 5, 16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 0, 16'h0000, 3, 5, 16'hBEEF, 16'hBEEF, 16'h0000};
    vecs[2] = '{1'b1, 2, 16'h1234, 2, 3, 16'h1234, 16'h0000, 16'hBEEF};
    vecs[3] = '{1'b0, 0, 16'h0000, 2, 2, 16'h1234, 16'h1234, 16'h1234};
    vecs[4] = '{1'b1, 2, 16'h5678, 2, 7, 16'h5678, 16'h1234, 16'h0000};

    rst_n = 1'b0; we = 0; waddr = 0; wdata = 0; raddr_a = 0; raddr_b = 0; clr_req = 0;
    model_reset();
    #12;
    check("reset rdata_a", 32'(rdata_a1), 0);
    check("reset rdata_b", 32'(rdata_b1), 0);
    check("reset busy", 32'(busy1), 0);
    check("reset wr_drop", 32'(drop1), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic write/read and bypass vectors
    for (int i = 0; i < 5; i++) begin
      step(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb, 1'b0);
      check($sformatf("vec%0d rdata_a byp", i), 32'(rdata_a1), 32'(vecs[i].exp_a1));
      check($sformatf("vec%0d rdata_a nobyp", i), 32'(rdata_a0), 32'(vecs[i].exp_a0));
      check($sformatf("vec%0d rdata_b", i), 32'(rdata_b1), 32'(vecs[i].exp_b));
    end

    // dual read: fill, then sweep A up and B down
    for (int i = 0; i < DEPTH; i++) step(1'b1, i, 16'(16'h1000 + i), 0, 0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 0, 16'h0, i, DEPTH - 1 - i, 1'b0);
      check("dual read a", 32'(rdata_a1), 32'(16'h1000 + i));
      check("dual read b", 32'(rdata_b1), 32'(16'h1000 + DEPTH - 1 - i));
    end

    // clear sweep
    step(1'b0, 0, 16'h0, 1, 2, 1'b1);
    cnt_busy = busy1 ? 1 : 0;
    guard = 0;
    while (busy1 && guard < 20) begin
      step(1'b0, 0, 16'h0, guard % DEPTH, 7, 1'b0);
      if (busy1) cnt_busy++;
      guard++;
    end
    check("clear busy cycles", 32'(cnt_busy), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 0, 16'h0, i, i, 1'b0);
      check("after clear", 32'(rdata_a1), 0);
    end

    // write and clr_req during a sweep
    for (int i = 0; i < DEPTH; i++) step(1'b1, i, 16'(16'h2000 + i), 0, 0, 1'b0);
    step(1'b0, 0, 16'h0, 0, 0, 1'b1);
    cnt_busy = busy1 ? 1 : 0;
    cnt_drop = 0;
    for (int k = 0; k < 12; k++) begin
      step(k == 2, 4, 16'hAAAA, 4, 4, (k >= 2 && k <= 4));
      if (busy1) cnt_busy++;
      if (drop1) cnt_drop++;
    end
    check("drop pulses", 32'(cnt_drop), 1);
    check("busy not extended", 32'(cnt_busy), DEPTH);
    step(1'b0, 0, 16'h0, 4, 3, 1'b0);
    check("dropped write addr4", 32'(rdata_a1), 0);

    // back-to-back sweeps with clr_req held
    cnt_low = 0;
    for (int k = 0; k < 2 * DEPTH + 1; k++) begin
      step(1'b0, 0, 16'h0, 0, 0, 1'b1);
      if (!busy1) cnt_low++;
    end
    check("idle gap between sweeps", 32'(cnt_low), 1);
    guard = 0;
    while (busy1 && guard < 20) begin
      step(1'b0, 0, 16'h0, 0, 0, 1'b0);
      guard++;
    end
    check("sweep finished", 32'(busy1), 0);

    // reset mid-sweep
    for (int i = 0; i < DEPTH; i++) step(1'b1, i, 16'(16'h3000 + i), 0, 0, 1'b0);
    step(1'b0, 0, 16'h0, 0, 0, 1'b1);
    step(1'b0, 0, 16'h0, 0, 0, 1'b0);
    step(1'b1, 5, 16'h5555, 0, 0, 1'b0);
    check("drop before reset", 32'(drop1), 1);
    #3;
    rst_n = 1'b0;
    we = 0; clr_req = 0;
    #1;
    check("midsweep reset busy", 32'(busy1), 0);
    check("midsweep reset drop", 32'(drop1), 0);
    check("midsweep reset rdata_a", 32'(rdata_a1), 0);
    check("midsweep reset rdata_b", 32'(rdata_b1), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 0, 16'h0, i, DEPTH - 1 - i, 1'b0);
      check("post reset a", 32'(rdata_a1), 0);
      check("post reset idle", 32'(busy1), 0);
    end

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), 16'($urandom),
           int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
           ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
